// File: rtl/apb_master_arbiter.sv
// rtl/apb_master_arbiter.sv - two-requester round-robin APB master with IDLE/SETUP/ACCESS sequencing
// Optional feature macro: APB_TIMEOUT_EN (abort ACCESS after WAIT_MAX wait cycles)
// Ports:
//   pclk, preset_n                        clock, synchronous active-low reset
//   reqN_valid/write/addr/wdata, reqN_ready    requester N transfer handshake (N=0,1)
//   rspN_valid/rdata/err                  requester N completion pulse and result
//   psel_x/penable/pwrite/paddr/pwdata    APB request side
//   pready/prdata/pslverr                 APB slave response
module apb_master_arbiter #(
  parameter int ADDR_W   = 3,
  parameter int DATA_W   = 8,
  parameter int WAIT_MAX = 15
) (
  input  logic              pclk,
  input  logic              preset_n,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp0_err,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              rsp1_err,
  output logic              psel_x,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic              pready,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pslverr
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  logic [1:0]        state;
  logic              last_grant;
  logic              owner;
  logic              grant0, grant1;
  logic              accept0, accept1;
  logic              done, abort, finish;
  logic [DATA_W-1:0] fin_rdata;
  logic              fin_err;

  assign psel_x  = (state != ST_IDLE);
  assign penable = (state == ST_ACCESS);

  // Round-robin: on a tie the requester that did not win last time gets the bus.
  assign grant0 = req0_valid && (!req1_valid || last_grant);
  assign grant1 = req1_valid && (!req0_valid || !last_grant);

  assign req0_ready = (state == ST_IDLE) && grant0;
  assign req1_ready = (state == ST_IDLE) && grant1;
  assign accept0    = req0_valid && req0_ready;
  assign accept1    = req1_valid && req1_ready;

  assign done = (state == ST_ACCESS) && pready;

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
  logic [CNT_W-1:0] wait_cnt;

  // pready=1 on the last allowed cycle still wins over the abort.
  assign abort = (state == ST_ACCESS) && !pready && (wait_cnt == CNT_W'(WAIT_MAX));

  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      wait_cnt <= '0;
    end else if (state == ST_SETUP) begin
      wait_cnt <= '0;
    end else if ((state == ST_ACCESS) && !pready && !abort) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  assign abort = 1'b0;
`endif

  assign finish = done || abort;

  // Aborted transfers report an error with zero data; writes never return data.
  always_comb begin
    fin_rdata = '0;
    fin_err   = 1'b1;
    if (done) begin
      fin_rdata = pwrite ? '0 : prdata;
      fin_err   = pslverr;
    end
  end

  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      pwrite     <= 1'b0;
      paddr      <= '0;
      pwdata     <= '0;
      rsp0_valid <= 1'b0;
      rsp0_rdata <= '0;
      rsp0_err   <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp1_rdata <= '0;
      rsp1_err   <= 1'b0;
    end else begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept0 || accept1) begin
            pwrite     <= accept1 ? req1_write : req0_write;
            paddr      <= accept1 ? req1_addr  : req0_addr;
            pwdata     <= accept1 ? req1_wdata : req0_wdata;
            owner      <= accept1;
            last_grant <= accept1;
            state      <= ST_SETUP;
          end
        end
        ST_SETUP: state <= ST_ACCESS;
        ST_ACCESS: begin
          if (finish) begin
            state <= ST_IDLE;
            if (owner) begin
              rsp1_valid <= 1'b1;
              rsp1_rdata <= fin_rdata;
              rsp1_err   <= fin_err;
            end else begin
              rsp0_valid <= 1'b1;
              rsp0_rdata <= fin_rdata;
              rsp0_err   <= fin_err;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb/tb_apb_master_arbiter.sv - scoreboard bench for apb_master_arbiter
module tb_apb_master_arbiter;

  logic       pclk = 1'b0;
  logic       preset_n;
  logic       req0_valid, req0_write, req1_valid, req1_write;
  logic [2:0] req0_addr, req1_addr;
  logic [7:0] req0_wdata, req1_wdata;
  logic       req0_ready, req1_ready;
  logic       rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
  logic [7:0] rsp0_rdata, rsp1_rdata;
  logic       psel_x, penable, pwrite, pready, pslverr;
  logic [2:0] paddr;
  logic [7:0] pwdata, prdata;

  int checks = 0;
  int failures = 0;

  int         slv_waits = 0;
  logic [7:0] slv_rdata = 8'h00;
  logic       slv_err   = 1'b0;
  int         acc_cnt   = 0;
  int         cur_len   = 0;
  int         last_len  = 0;
  logic [2:0] acc_addr  = 3'd0;
  logic       addr_stable = 1'b1;

  typedef struct {
    logic       port;
    logic [7:0] rdata;
    logic       err;
  } exp_t;
  exp_t exp_q[$];

  apb_master_arbiter #(.ADDR_W(3), .DATA_W(8), .WAIT_MAX(15)) dut (
    .pclk(pclk), .preset_n(preset_n),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready), .rsp0_valid(rsp0_valid),
    .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready), .rsp1_valid(rsp1_valid),
    .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .psel_x(psel_x), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  assign prdata  = slv_rdata;
  assign pslverr = slv_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Slave model: asserts pready after slv_waits ACCESS cycles.
  always @(negedge pclk) begin
    if (psel_x && penable) begin
      pready = (acc_cnt == slv_waits);
      acc_cnt++;
    end else begin
      pready  = 1'b0;
      acc_cnt = 0;
    end
  end

  // ACCESS length and paddr stability tracker.
  always @(negedge pclk) begin
    if (penable) begin
      if (cur_len == 0) begin
        acc_addr    = paddr;
        addr_stable = 1'b1;
      end else if (paddr !== acc_addr) begin
        addr_stable = 1'b0;
      end
      cur_len++;
    end else if (cur_len != 0) begin
      last_len = cur_len;
      cur_len  = 0;
    end
  end

  // Response monitor: every rsp pulse must match the oldest expectation.
  always @(negedge pclk) begin
    if (rsp0_valid || rsp1_valid) begin
      exp_t e;
      chk("rsp_exclusive", {31'd0, rsp0_valid && rsp1_valid}, 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_port", {31'd0, rsp1_valid}, {31'd0, e.port});
        chk("rsp_rdata", {24'd0, rsp1_valid ? rsp1_rdata : rsp0_rdata}, {24'd0, e.rdata});
        chk("rsp_err", {31'd0, rsp1_valid ? rsp1_err : rsp0_err}, {31'd0, e.err});
      end
    end
  end

  task automatic push_exp(input logic port, input logic wr, input logic err);
    exp_t e;
    e.port  = port;
    e.rdata = (wr || (slv_err && 1'b0)) ? 8'h00 : slv_rdata;
    e.err   = err;
    exp_q.push_back(e);
  endtask

  task automatic xfer(input logic port, input logic wr, input logic [2:0] addr, input logic [7:0] wd);
    bit got = 0;
    if (port) begin
      req1_valid = 1; req1_write = wr; req1_addr = addr; req1_wdata = wd;
    end else begin
      req0_valid = 1; req0_write = wr; req0_addr = addr; req0_wdata = wd;
    end
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge pclk);
      if (port ? req1_ready : req0_ready) begin
        got = 1;
        push_exp(port, wr, slv_err);
      end
    end
    if (!got) chk("ready_timeout", 32'd1, 32'd0);
    @(posedge pclk); #1;
    req0_valid = 0; req1_valid = 0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int c = 0; c < 300 && !ok; c++) begin
      @(negedge pclk);
      if (exp_q.size() == 0 && !psel_x) ok = 1;
    end
    if (!ok) chk("idle_timeout", 32'd1, 32'd0);
    @(posedge pclk); #1;
  endtask

  // Both requesters held valid; grants must alternate starting with requester 0.
  task automatic both_loop(input int num);
    int n = 0;
    req0_valid = 1; req1_valid = 1;
    for (int c = 0; c < 20 * num && n < num; c++) begin
      @(negedge pclk);
      if (req0_ready || req1_ready) begin
        chk("ready_onehot", {31'd0, req0_ready && req1_ready}, 32'd0);
        chk("grant_order", {31'd0, req1_ready}, n % 2);
        push_exp(req1_ready, req1_ready ? req1_write : req0_write, 1'b0);
        n++;
      end
    end
    chk("grant_count", n, num);
    @(posedge pclk); #1;
    req0_valid = 0; req1_valid = 0;
  endtask

  task automatic do_reset();
    preset_n = 0;
    @(posedge pclk); @(posedge pclk); #1;
    preset_n = 1;
    exp_q.delete();
  endtask

  task automatic wait_access();
    bit ok = 0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge pclk);
      if (penable) ok = 1;
    end
    if (!ok) chk("access_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    preset_n = 0;
    req0_valid = 0; req0_write = 0; req0_addr = 0; req0_wdata = 0;
    req1_valid = 0; req1_write = 0; req1_addr = 0; req1_wdata = 0;
    @(posedge pclk); @(posedge pclk); #1;
    preset_n = 1;

    // Reset state.
    @(negedge pclk);
    chk("rst_psel", psel_x, 0);
    chk("rst_penable", penable, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_rsp0", {rsp0_valid, rsp0_err, rsp0_rdata}, 0);
    chk("rst_rsp1", {rsp1_valid, rsp1_err, rsp1_rdata}, 0);
    chk("rst_ready", {req0_ready, req1_ready}, 0);

    // Test 1: cycle-exact write with zero wait states.
    @(posedge pclk); #1;
    slv_waits = 0; slv_rdata = 8'h77; slv_err = 0;
    req0_valid = 1; req0_write = 1; req0_addr = 3'd3; req0_wdata = 8'hA5;
    @(negedge pclk);
    chk("c0_ready", req0_ready, 1);
    chk("c0_psel", psel_x, 0);
    push_exp(1'b0, 1'b1, 1'b0);
    @(posedge pclk); #1;
    req0_valid = 0;
    @(negedge pclk);
    chk("c1_phase", {psel_x, penable, req0_ready}, 3'b100);
    @(negedge pclk);
    chk("c2_phase", {psel_x, penable}, 2'b11);
    chk("c2_paddr", paddr, 3);
    chk("c2_pwdata", pwdata, 8'hA5);
    chk("c2_pwrite", pwrite, 1);
    @(negedge pclk);
    chk("c3_rsp0", rsp0_valid, 1);
    chk("c3_psel", psel_x, 0);
    wait_idle();

    // Test 2: read with two wait states, paddr stable.
    slv_waits = 2; slv_rdata = 8'h3C;
    xfer(1'b1, 1'b0, 3'd5, 8'h00);
    wait_idle();
    chk("t2_access_len", last_len, 3);
    chk("t2_addr_stable", addr_stable, 1);
    chk("t2_addr", acc_addr, 5);

    // Test 3: both held, four alternating grants.
    slv_waits = 0; slv_rdata = 8'h5A;
    req0_write = 1; req0_addr = 3'd1; req0_wdata = 8'h10;
    req1_write = 0; req1_addr = 3'd4;
    both_loop(4);
    wait_idle();

    // Test 4: slave error then a normal transfer.
    slv_err = 1;
    xfer(1'b0, 1'b1, 3'd7, 8'hEE);
    wait_idle();
    chk("t4_idle", psel_x, 0);
    slv_err = 0; slv_rdata = 8'h11;
    xfer(1'b1, 1'b0, 3'd2, 8'h00);
    wait_idle();

    // Test 5: reset during ACCESS, then tie goes to requester 0.
    slv_waits = 1000;
    req1_valid = 1; req1_write = 0; req1_addr = 3'd6;
    wait_access();
    req1_valid = 0;
    @(posedge pclk); #1;
    preset_n = 0;
    @(posedge pclk);
    @(negedge pclk);
    chk("t5_rst_phase", {psel_x, penable}, 0);
    chk("t5_no_rsp", {rsp0_valid, rsp1_valid}, 0);
    @(posedge pclk); #1;
    preset_n = 1;
    slv_waits = 0; slv_rdata = 8'h21;
    req0_write = 0; req0_addr = 3'd0;
    req1_write = 0; req1_addr = 3'd6;
    both_loop(2);
    wait_idle();

    // Test 6: slave never ready.
    slv_waits = 1000; slv_rdata = 8'hFF;
`ifdef APB_TIMEOUT_EN
    begin
      exp_t e;
      xfer(1'b0, 1'b0, 3'd2, 8'h00);
      void'(exp_q.pop_back());
      e.port = 1'b0; e.rdata = 8'h00; e.err = 1'b1;
      exp_q.push_back(e);
      wait_idle();
      chk("t6_abort_len", last_len, 16);
    end
`else
    req0_valid = 1; req0_write = 0; req0_addr = 3'd2;
    wait_access();
    req0_valid = 0;
    repeat (100) @(negedge pclk);
    chk("t6_still_access", {psel_x, penable}, 2'b11);
    chk("t6_no_rsp", {rsp0_valid, rsp1_valid}, 0);
    @(posedge pclk); #1;
    do_reset();
`endif

    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
